// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm truth-table scanner.
// No logic; no latency.
// No handshakes; constants only.
package minterm_pkg;

    localparam int N_INPUTS_DEFAULT = 4;
    localparam int TABLE_W          = 1 << N_INPUTS_DEFAULT;
    localparam int SETTLE_W         = 4;

    // Golden table of the reference function: minterms 1,5,9,13,15
    localparam logic [TABLE_W-1:0] EXPECTED_TABLE = 16'hA222;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter that stops at zero and flags it.
// Load and decrement take effect on the next clock edge; zero flag is combinational.
// No handshakes; load has priority over decrement.
module settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/minterm_scanner.sv
// Sweeps every input vector through an external function stage and packs the results into a truth table.
// SETTLE_CYCLES+2 cycles per vector, 2^N_INPUTS vectors, then a one-cycle done pulse.
// No backpressure; start is only honoured in IDLE. Optional compare via MINTERM_SCANNER_COMPARE_EN.
module minterm_scanner
    import minterm_pkg::*;
#(
    parameter int N_INPUTS      = N_INPUTS_DEFAULT,
    parameter int SETTLE_CYCLES = 1
`ifdef MINTERM_SCANNER_COMPARE_EN
    ,
    parameter logic [(1<<N_INPUTS)-1:0] EXPECTED_TABLE = minterm_pkg::EXPECTED_TABLE
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       fn_result,
    output logic [N_INPUTS-1:0]        vec_out,
    output logic                       vec_valid,
    output logic                       busy,
    output logic                       done,
    output logic [(1<<N_INPUTS)-1:0]   table_out,
    output logic [N_INPUTS:0]          ones_count
`ifdef MINTERM_SCANNER_COMPARE_EN
    ,
    output logic                       mismatch
`endif
);

    localparam int TW = 1 << N_INPUTS;
    localparam int CW = N_INPUTS + 1;

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] vec_q, vec_d;
    logic [TW-1:0]       table_q, table_d;
    logic [CW-1:0]       ones_q, ones_d;
    logic                cnt_load, cnt_dec, cnt_zero;
    logic                last_vec;

    assign last_vec = (vec_q == {N_INPUTS{1'b1}});

    settle_counter #(
        .W (SETTLE_W)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_W'(SETTLE_CYCLES)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        table_d  = table_q;
        ones_d   = ones_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = DRIVE;
                    vec_d    = '0;
                    table_d  = '0;
                    ones_d   = '0;
                    cnt_load = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SAMPLE: begin
                table_d[vec_q] = fn_result;
                ones_d         = ones_q + CW'(fn_result);
                // Terminal vector exits instead of wrapping vec_out back to 0
                if (last_vec) begin
                    state_d = DONE;
                end else begin
                    vec_d    = vec_q + N_INPUTS'(1);
                    cnt_load = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            ones_q  <= ones_d;
        end
    end

    assign vec_out    = vec_q;
    assign table_out  = table_q;
    assign ones_count = ones_q;
    assign vec_valid  = (state_q == DRIVE) || (state_q == SAMPLE);
    assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done       = (state_q == DONE);

`ifdef MINTERM_SCANNER_COMPARE_EN
    logic mismatch_q;

    // Compare against the completed table so the flag is valid during the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            mismatch_q <= 1'b0;
        end else if ((state_q == SAMPLE) && (state_d == DONE)) begin
            mismatch_q <= (table_d != EXPECTED_TABLE);
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: doc/minterm_scanner.md
Name: minterm_scanner

Overview:
- Sequential truth-table sweeper for the 4-input minterm function stage.
- On `start`, drives every input vector {a,b,c,d} = 0..15 into the function stage.
- For each vector, waits a settle interval, samples the function's 1-bit result and packs it into a 2^N-bit table.
- Reports the finished table, a ones count and a done pulse; replaces the bench's #1 loop with synthesizable logic.

Parameters:
- N_INPUTS, 4: number of function inputs; table width is 2^N_INPUTS.
- SETTLE_CYCLES, 1: idle cycles between driving a vector and sampling the result (range 0..15).
- EXPECTED_TABLE, 16'hA222: golden table for the compare feature (minterms 1,5,9,13,15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- fn_result  in  1  result from the function stage for the currently driven vector.
- vec_out  out  N_INPUTS  current input vector {a,b,c,d}, a = MSB.
- vec_valid  out  1  high while vec_out is being driven (DRIVE and SAMPLE states).
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse when the table is complete.
- table_out  out  2^N_INPUTS  bit i = fn_result sampled for vector i.
- ones_count  out  N_INPUTS+1  number of set bits in table_out (the minterm count).

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values (immediate, async): state IDLE; vec_out 0; vec_valid, busy, done 0; table_out 0; ones_count 0; settle counter 0.
- State machine:
  - IDLE: start=1 → DRIVE. On transition: clear table_out and ones_count, vec_out=0, settle counter=SETTLE_CYCLES.
  - DRIVE: vec_valid=1. Counter nonzero → decrement. Counter zero → SAMPLE.
  - SAMPLE: table_out[vec_out] <= fn_result; ones_count += fn_result.
    - vec_out == 2^N-1 → DONE.
    - Otherwise vec_out++, reload counter, → DRIVE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Timing: each vector takes SETTLE_CYCLES+2 cycles (DRIVE entry through SAMPLE). A full sweep is 16*(SETTLE_CYCLES+2) cycles after the start edge, plus the DONE cycle.
- vec_out is stable from the DRIVE entry through SAMPLE; it never changes in the sampling cycle.
- start while busy or in DONE: ignored, no restart.
- table_out and ones_count hold the last sweep until the next accepted start.
- vec_out wrap: the counter never wraps to 0 inside a sweep; the terminal vector exits to DONE.
- Reset mid-sweep: abort immediately; all outputs return to reset values; no done pulse.
- ones_count width holds the all-ones case: 16 needs 5 bits.

Optional Feature:
- Macro: MINTERM_SCANNER_COMPARE_EN.
- Defined: adds output `mismatch` (1 bit, reset 0), updated in the DONE cycle to (table_out != EXPECTED_TABLE); cleared on an accepted start.
- Undefined: no mismatch port, no compare logic.

Decomposition:
- Package `minterm_pkg`:
  - state enum {IDLE, DRIVE, SAMPLE, DONE};
  - default N_INPUTS;
  - EXPECTED_TABLE constant 16'hA222;
  - TABLE_W = 1<<N_INPUTS.
- Sub-module `settle_counter`: loadable down-counter with a zero flag, reused for the per-vector wait.
- All other logic stays in minterm_scanner.

Test Plan:
- Reference function connected (result = ~c&d | a&b&c&d), SETTLE_CYCLES=1, start pulse → after 48 cycles done=1 for one cycle, table_out=16'hA222, ones_count=5, mismatch=0 (with macro).
- fn_result tied 1, SETTLE_CYCLES=0 → done after 32 cycles, table_out=16'hFFFF, ones_count=16; tied 0 → 16'h0000, 0.
- start re-pulsed at cycle 10 of a sweep → ignored; single done at the original cycle, table unchanged from the expected result.
- rst_n low at vector 7 → all outputs 0 asynchronously; after release and a new start, a full correct sweep completes.
- Function stage replaced by constant ~d, macro defined → table_out=16'h5555, mismatch=1; next start clears mismatch to 0 immediately.
- Each SAMPLE cycle: vec_valid=1 and vec_out equals the sweep index; vec_out steps 0..15 with no skips.
